// File: rtl/sobel_window.sv
// Streaming 3x3 neighbourhood generator feeding the sobel stage.
// Two shift-register line buffers plus a two-column history build each window; only in-image windows are emitted.
module sobel_window #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pix,
    output logic             out_valid,
    output logic             out_eof,
    output logic [PIX_W:0]   p0,
    output logic [PIX_W:0]   p1,
    output logic [PIX_W:0]   p2,
    output logic [PIX_W:0]   p3,
    output logic [PIX_W:0]   p5,
    output logic [PIX_W:0]   p6,
    output logic [PIX_W:0]   p7,
    output logic [PIX_W:0]   p8
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [PIX_W-1:0] r_lb1 [IMG_W];
    logic [PIX_W-1:0] r_lb0 [IMG_W];
    // [1] holds column c-1, [0] holds column c-2 relative to the next pixel
    logic [1:0][PIX_W-1:0] r_top, r_mid, r_bot;
    logic r_valid, r_eof;
    logic [PIX_W-1:0] r_p0, r_p1, r_p2, r_p3, r_p5, r_p6, r_p7, r_p8;

    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic w_emit, w_last, w_acc;
    logic [PIX_W-1:0] w_lb1_tail, w_lb0_tail;

    // in_sof re-bases the current pixel to (0,0), abandoning any partial frame
    always_comb begin
        w_col      = in_sof ? '0 : r_col;
        w_row      = in_sof ? '0 : r_row;
        w_emit     = (w_row >= RW'(2)) && (w_col >= CW'(2));
        w_last     = (w_row == ROW_LAST) && (w_col == COL_LAST);
        w_acc      = in_valid && !rst;
        w_lb1_tail = r_lb1[IMG_W-1];
        w_lb0_tail = r_lb0[IMG_W-1];
    end

    // Line buffers and column history carry no reset; the counters gate out stale data.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_lb1[0] <= in_pix;
            r_lb0[0] <= w_lb1_tail;
            for (int i = 1; i < IMG_W; i++) begin
                r_lb1[i] <= r_lb1[i-1];
                r_lb0[i] <= r_lb0[i-1];
            end
            r_top <= {w_lb0_tail, r_top[1]};
            r_mid <= {w_lb1_tail, r_mid[1]};
            r_bot <= {in_pix,     r_bot[1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_valid <= 1'b0;
            r_eof   <= 1'b0;
            r_p0    <= '0;
            r_p1    <= '0;
            r_p2    <= '0;
            r_p3    <= '0;
            r_p5    <= '0;
            r_p6    <= '0;
            r_p7    <= '0;
            r_p8    <= '0;
        end else begin
            r_valid <= in_valid && w_emit;
            r_eof   <= in_valid && w_emit && w_last;
            if (in_valid) begin
                if (w_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
                end else begin
                    r_col <= w_col + 1'b1;
                    r_row <= w_row;
                end
                // Outputs only load on an emitted window so p* hold between windows
                if (w_emit) begin
                    r_p0 <= r_top[0];
                    r_p1 <= r_top[1];
                    r_p2 <= w_lb0_tail;
                    r_p3 <= r_mid[0];
                    r_p5 <= w_lb1_tail;
                    r_p6 <= r_bot[0];
                    r_p7 <= r_bot[1];
                    r_p8 <= in_pix;
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign out_eof   = r_eof;
    assign p0 = {1'b0, r_p0};
    assign p1 = {1'b0, r_p1};
    assign p2 = {1'b0, r_p2};
    assign p3 = {1'b0, r_p3};
    assign p5 = {1'b0, r_p5};
    assign p6 = {1'b0, r_p6};
    assign p7 = {1'b0, r_p7};
    assign p8 = {1'b0, r_p8};
endmodule
